// File: rtl/alu_exec_unit.sv
// Handshaked 32-bit execute unit: one op per in/out transfer pair, iterative 1-bit/cycle shifts.
// Define ALU_EXEC_BARREL_EN to compute SLL/SRL combinationally at acceptance (no SHIFT state).
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_ctrl,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [4:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        illegal
);
    // state | meaning
    // IDLE  | waiting for an operation, in_ready high
    // SHIFT | iterative shift in progress (iterative build only)
    // DONE  | result and flags presented, waiting for out_ready
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;

`ifdef ALU_EXEC_BARREL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_SHIFT = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic        ill_q, ill_d;
`ifndef ALU_EXEC_BARREL_EN
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic [31:0] shifted;
`endif

    logic [31:0] sum, diff, op_res;
    logic        op_ovf, op_ill;

    always_comb begin
        sum    = src_a + src_b;
        diff   = src_a - src_b;
        op_res = 32'd0;
        op_ovf = 1'b0;
        op_ill = 1'b0;
        case (alu_ctrl)
            OP_AND:  op_res = src_a & src_b;
            OP_OR:   op_res = src_a | src_b;
            OP_NOR:  op_res = ~(src_a | src_b);
            OP_ADD, OP_ADDI: begin
                op_res = sum;
                op_ovf = (src_a[31] == src_b[31]) && (sum[31] != src_a[31]);
            end
            OP_SUB: begin
                op_res = diff;
                op_ovf = (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);
            end
            // Direct signed compare stays correct when a-b overflows
            OP_SLT:  op_res = {31'd0, $signed(src_a) < $signed(src_b)};
`ifdef ALU_EXEC_BARREL_EN
            OP_SLL:  op_res = src_b << shamt;
            OP_SRL:  op_res = src_b >> shamt;
`else
            OP_SLL, OP_SRL: op_res = src_b;
`endif
            default: op_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
`ifndef ALU_EXEC_BARREL_EN
        cnt_d    = cnt_q;
        left_d   = left_q;
        shifted  = left_q ? (result_q << 1) : (result_q >> 1);
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    result_d = op_res;
                    zero_d   = (op_res == 32'd0);
                    ovf_d    = op_ovf;
                    ill_d    = op_ill;
                    state_d  = S_DONE;
`ifndef ALU_EXEC_BARREL_EN
                    if ((alu_ctrl == OP_SLL || alu_ctrl == OP_SRL) && shamt != 5'd0) begin
                        state_d = S_SHIFT;
                        cnt_d   = shamt;
                        left_d  = (alu_ctrl == OP_SLL);
                    end
`endif
                end
            end
`ifndef ALU_EXEC_BARREL_EN
            S_SHIFT: begin
                result_d = shifted;
                cnt_d    = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    zero_d  = (shifted == 32'd0);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= 32'd0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifndef ALU_EXEC_BARREL_EN
            cnt_q    <= 5'd0;
            left_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
`ifndef ALU_EXEC_BARREL_EN
            cnt_q    <= cnt_d;
            left_q   <= left_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic, overflow = result out of 32-bit signed range
    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] res, output logic ov,
                         output logic il, output int lat);
        longint sa, sb, s;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 32'd0; ov = 1'b0; il = 1'b0; lat = 1;
        case (c)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b1100: res = ~(a | b);
            4'b0010, 4'b0100, 4'b0110: begin
                s   = (c == 4'b0110) ? sa - sb : sa + sb;
                ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                res = s[31:0];
            end
            4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011, 4'b1000: begin
                res = (c == 4'b0011) ? (b << sh) : (b >> sh);
`ifndef ALU_EXEC_BARREL_EN
                lat = int'(sh) + 1;
`endif
            end
            default: il = 1'b1;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int hold);
        logic [31:0] er;
        logic        eo, ei;
        int          elat, lat;
        logic [31:0] r0;
        model(c, a, b, sh, er, eo, ei, elat);
        @(negedge clk);
        chk({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; alu_ctrl = c; src_a = a; src_b = b; shamt = sh;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom); src_a = $urandom; src_b = $urandom; shamt = 5'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " result"}, result, er);
        chk({tag, " zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
        chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
        chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, ei});
        chk({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
        r0 = er;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, " hold result"}, result, r0);
            chk({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " post out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " post in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [3:0] codes [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                              4'b0110, 4'b0111, 4'b1000, 4'b1100};

    initial begin
        int seen;
        logic [3:0] c;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = 4'd0; src_a = 32'd0; src_b = 32'd0; shamt = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {29'd0, zero, overflow, illegal}, 32'd0);
        rst = 1'b0;

        run_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, 0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 0);
        run_op("slt_neg", 4'b0111, 32'h80000000, 32'd1, 5'd0, 0);
        run_op("slt_ovf", 4'b0111, 32'h7FFFFFFF, 32'h80000000, 5'd0, 0);
        run_op("sub_ovf", 4'b0110, 32'h80000000, 32'd1, 5'd0, 0);
        run_op("nor", 4'b1100, 32'd0, 32'd0, 5'd0, 0);
        run_op("srl31", 4'b1000, 32'h80000000, 32'h80000000, 5'd31, 0);
        run_op("sll0", 4'b0011, 32'hDEADBEEF, 32'd3, 5'd0, 0);
        run_op("sll_out", 4'b0011, 32'd0, 32'h80000001, 5'd1, 0);
        run_op("add_bp", 4'b0010, 32'd1, 32'd2, 5'd0, 5);
        run_op("illegal", 4'b1111, 32'h12345678, 32'h9, 5'd0, 0);
        run_op("illegal5", 4'b0101, 32'd0, 32'd0, 5'd0, 0);
        run_op("addi", 4'b0100, 32'd10, 32'hFFFFFFFD, 5'd0, 0);

        // Abort an in-flight shift with reset
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'b0011; src_b = 32'd1; shamt = 5'd20;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_abort out_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_abort no result", 32'(seen), 32'd0);
        run_op("and_after", 4'b0000, 32'hF0, 32'h3C, 5'd0, 0);

        for (int i = 0; i < 40; i++) begin
            c = (i % 10 == 9) ? 4'($urandom) : codes[$urandom_range(0, 8)];
            run_op($sformatf("rnd%0d", i), c, $urandom, ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom,
                   5'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
